pwm_ramp: RTL and testbench

- Upstream feeder for the PWM/PDM output stage.
- Holds a software-set target duty with fractional resolution and slews the current duty toward it by a programmable step once per PWM period.
- Presents the integer duty on a stream interface consumed at each period boundary. Optionally, first-order dithering of the fractional bits gives sub-LSB average resolution.

---
 rtl/pwm_ramp.sv | 127 ++++++++++++
 tb/tb_pwm_ramp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp.sv
// Duty slew/dither feeder for the PWM stage: ramps cur toward tgt by stp once per period.
// Latency: cur updates on the str_rdy tick, str_dat follows one cycle later (one period to the PWM).
// Backpressure: none; str_rdy is a period-boundary tick, str_dat is held between ticks. Option macro: PWM_RAMP_DITHER_EN.
module pwm_ramp #(
  parameter int              CCW = 8,
  parameter int              FRW = 8,
  parameter logic [CCW-1:0]  CCE = '1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [CCW+FRW-1:0] cfg_val,
  input  logic [CCW+FRW-1:0] cfg_stp,
  input  logic               cfg_upd,
  output logic               cfg_bsy,
  output logic [CCW+FRW-1:0] cur_val,
  output logic [CCW-1:0]     str_dat,
  input  logic               str_rdy
);

  localparam int W = CCW + FRW;

  typedef enum logic [1:0] {IDLE, UP, DN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   tgt, tgt_nxt;
  logic [W-1:0]   stp, stp_nxt;
  logic [W-1:0]   cur, cur_nxt;
  logic [W-1:0]   cfg_clamp;
  logic [W:0]     sum, diff;
  logic           tick_d;
  logic [CCW-1:0] str_nxt;

  // Clamp the requested target so its integer part never exceeds CCE; a clamped fraction is dropped.
  always_comb begin
    cfg_clamp = cfg_val;
    if (cfg_val[W-1:FRW] >= CCE)
      cfg_clamp = {CCE, {FRW{1'b0}}};
    tgt_nxt = cfg_upd ? cfg_clamp : tgt;
    stp_nxt = cfg_upd ? cfg_stp : stp;
  end

  // Slew step on a tick using the old tgt/stp, then pick the direction from the updated cur vs. the
  // target that will be in force next; this lets a retarget reverse direction without overshoot.
  always_comb begin
    cur_nxt = cur;
    sum     = {1'b0, cur} + {1'b0, stp};
    diff    = {1'b0, cur} - {1'b0, stp};
    if (str_rdy) begin
      case (state)
        UP: begin
          if (stp == '0 || sum >= {1'b0, tgt})
            cur_nxt = tgt;
          else
            cur_nxt = sum[W-1:0];
        end
        DN: begin
          if (stp == '0 || diff[W] || diff[W-1:0] <= tgt)
            cur_nxt = tgt;
          else
            cur_nxt = diff[W-1:0];
        end
        default: cur_nxt = cur;
      endcase
    end
    if (cur_nxt < tgt_nxt)
      state_nxt = UP;
    else if (cur_nxt > tgt_nxt)
      state_nxt = DN;
    else
      state_nxt = IDLE;
  end

  // Config, current duty and FSM state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tgt    <= '0;
      stp    <= '0;
      cur    <= '0;
      state  <= IDLE;
      tick_d <= 1'b0;
    end else begin
      tgt    <= tgt_nxt;
      stp    <= stp_nxt;
      cur    <= cur_nxt;
      state  <= state_nxt;
      tick_d <= str_rdy;
    end
  end

`ifdef PWM_RAMP_DITHER_EN
  logic [FRW-1:0] acc;
  logic [FRW:0]   acc_sum;
  logic [CCW:0]   dith;

  // First-order dither: carry out of the fraction accumulator bumps the integer duty, saturating at CCE.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, cur[FRW-1:0]};
    dith    = {1'b0, cur[W-1:FRW]} + {{CCW{1'b0}}, acc_sum[FRW]};
    str_nxt = (dith > {1'b0, CCE}) ? CCE : dith[CCW-1:0];
  end

  // Accumulator advances once per period alongside the output register; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rstn)
      acc <= '0;
    else if (tick_d)
      acc <= acc_sum[FRW-1:0];
  end
`else
  // Without dither the fraction is simply truncated.
  always_comb begin
    str_nxt = cur[W-1:FRW];
  end
`endif

  // Output duty is captured the cycle after a tick and held until the next one.
  always_ff @(posedge clk) begin
    if (!rstn)
      str_dat <= '0;
    else if (tick_d)
      str_dat <= str_nxt;
  end

  assign cfg_bsy = (state != IDLE);
  assign cur_val = cur;

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp (CCW=8, FRW=8, CCE=255).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Works in both the plain and PWM_RAMP_DITHER_EN builds.
module tb_pwm_ramp;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_val;
  logic [15:0] cfg_stp;
  logic        cfg_upd;
  logic        cfg_bsy;
  logic [15:0] cur_val;
  logic [7:0]  str_dat;
  logic        str_rdy;

  int checks = 0;
  int errors = 0;

  pwm_ramp #(.CCW(8), .FRW(8), .CCE(8'hFF)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .cfg_val (cfg_val),
    .cfg_stp (cfg_stp),
    .cfg_upd (cfg_upd),
    .cfg_bsy (cfg_bsy),
    .cur_val (cur_val),
    .str_dat (str_dat),
    .str_rdy (str_rdy)
  );

  always #5 clk = ~clk;

  // One clock cycle with the given tick/update strobes, then settle past the edge.
  task automatic cyc(input logic rdy, input logic upd);
    str_rdy = rdy;
    cfg_upd = upd;
    @(posedge clk);
    #1;
    str_rdy = 1'b0;
    cfg_upd = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] v, input logic [15:0] s);
    cfg_val = v;
    cfg_stp = s;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    set_cfg(16'h0000, 16'h0000);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      checks++;
      if (str_dat !== 8'h00 || cur_val !== 16'h0000 || cfg_bsy !== 1'b0) begin
        errors++;
        $display("FAIL reset_tick%0d: str_dat=%h cur_val=%h bsy=%b, want 00/0000/0", i, str_dat, cur_val, cfg_bsy);
      end
    end
  endtask

  task automatic test_jump;
    set_cfg(16'h4000, 16'h0000);
    cyc(1'b0, 1'b1);
    checks++;
    if (cfg_bsy !== 1'b1 || cur_val !== 16'h0000) begin
      errors++;
      $display("FAIL jump_latch: bsy=%b cur_val=%h, want 1/0000", cfg_bsy, cur_val);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (cfg_bsy !== 1'b1) begin
      errors++;
      $display("FAIL jump_wait_bsy: bsy=%b, want 1", cfg_bsy);
    end
    cyc(1'b1, 1'b0);
    checks++;
    if (cur_val !== 16'h4000 || cfg_bsy !== 1'b0 || str_dat !== 8'h00) begin
      errors++;
      $display("FAIL jump_tick: cur_val=%h bsy=%b str_dat=%h, want 4000/0/00", cur_val, cfg_bsy, str_dat);
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (str_dat !== 8'h40) begin
      errors++;
      $display("FAIL jump_str: str_dat=%h, want 40", str_dat);
    end
  endtask

  task automatic ramp_check(input string name, input logic [15:0] exp_cur, input logic exp_bsy);
    cyc(1'b1, 1'b0);
    checks++;
    if (cur_val !== exp_cur || cfg_bsy !== exp_bsy) begin
      errors++;
      $display("FAIL %s: cur_val=%h bsy=%b, want %h/%b", name, cur_val, cfg_bsy, exp_cur, exp_bsy);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_ramp;
    set_cfg(16'h0000, 16'h0000);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    set_cfg(16'h1000, 16'h0400);
    cyc(1'b0, 1'b1);
    ramp_check("up1", 16'h0400, 1'b1);
    ramp_check("up2", 16'h0800, 1'b1);
    ramp_check("up3", 16'h0C00, 1'b1);
    ramp_check("up4", 16'h1000, 1'b0);
    checks++;
    if (str_dat !== 8'h10) begin
      errors++;
      $display("FAIL up_str: str_dat=%h, want 10", str_dat);
    end
    set_cfg(16'h0000, 16'h0400);
    cyc(1'b0, 1'b1);
    ramp_check("dn1", 16'h0C00, 1'b1);
    ramp_check("dn2", 16'h0800, 1'b1);
    ramp_check("dn3", 16'h0400, 1'b1);
    ramp_check("dn4", 16'h0000, 1'b0);
    checks++;
    if (str_dat !== 8'h00) begin
      errors++;
      $display("FAIL dn_str: str_dat=%h, want 00", str_dat);
    end
  endtask

  task automatic test_retarget;
    set_cfg(16'h1000, 16'h0400);
    cyc(1'b0, 1'b1);
    ramp_check("rt_up1", 16'h0400, 1'b1);
    ramp_check("rt_up2", 16'h0800, 1'b1);
    // Retarget coincides with a tick: this tick still uses the old target.
    set_cfg(16'h0600, 16'h0400);
    cyc(1'b1, 1'b1);
    checks++;
    if (cur_val !== 16'h0C00 || cfg_bsy !== 1'b1) begin
      errors++;
      $display("FAIL rt_same_tick: cur_val=%h bsy=%b, want 0C00/1", cur_val, cfg_bsy);
    end
    cyc(1'b0, 1'b0);
    ramp_check("rt_dn1", 16'h0800, 1'b1);
    ramp_check("rt_dn2", 16'h0600, 1'b0);
    ramp_check("rt_hold", 16'h0600, 1'b0);
  endtask

  task automatic test_dither;
    int sum;
    int bad;
    logic [7:0] prev;
    set_cfg(16'h4080, 16'h0000);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    sum = 0;
    bad = 0;
    prev = str_dat;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      sum += int'(str_dat);
`ifdef PWM_RAMP_DITHER_EN
      if ((str_dat !== 8'h40 && str_dat !== 8'h41) || str_dat === prev) bad++;
`else
      if (str_dat !== 8'h40) bad++;
`endif
      prev = str_dat;
    end
    checks++;
`ifdef PWM_RAMP_DITHER_EN
    if (sum !== 16512) begin
      errors++;
      $display("FAIL dither_sum: sum=%0d, want 16512", sum);
    end
`else
    if (sum !== 16384) begin
      errors++;
      $display("FAIL dither_sum: sum=%0d, want 16384", sum);
    end
`endif
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL dither_pattern: %0d bad periods, want 0", bad);
    end
  endtask

  task automatic test_saturation_reset;
    set_cfg(16'hFFFF, 16'h0000);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (cur_val !== 16'hFF00 || str_dat !== 8'hFF) begin
      errors++;
      $display("FAIL sat_latch: cur_val=%h str_dat=%h, want FF00/FF", cur_val, str_dat);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      checks++;
      if (str_dat !== 8'hFF) begin
        errors++;
        $display("FAIL sat_hold%0d: str_dat=%h, want FF", i, str_dat);
      end
    end
    set_cfg(16'h0000, 16'h0100);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    checks++;
    if (cur_val !== 16'hFD00 || cfg_bsy !== 1'b1) begin
      errors++;
      $display("FAIL mid_ramp: cur_val=%h bsy=%b, want FD00/1", cur_val, cfg_bsy);
    end
    rstn = 1'b0;
    cyc(1'b1, 1'b0);
    checks++;
    if (str_dat !== 8'h00 || cur_val !== 16'h0000 || cfg_bsy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: str_dat=%h cur_val=%h bsy=%b, want 00/0000/0", str_dat, cur_val, cfg_bsy);
    end
    rstn = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    checks++;
    if (str_dat !== 8'h00 || cur_val !== 16'h0000 || cfg_bsy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: str_dat=%h cur_val=%h bsy=%b, want 00/0000/0", str_dat, cur_val, cfg_bsy);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    cfg_val = '0;
    cfg_stp = '0;
    cfg_upd = 1'b0;
    str_rdy = 1'b0;
    #1;
    test_reset();
    test_jump();
    test_ramp();
    test_retarget();
    test_dither();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
